// File: rtl/db_arbiter_pkg.sv
// Shared types for the data-break arbiter: FSM states, requester index and the
// CPU major-state code that marks the memory cycle of a break (DB2).
// Rotating priority is enabled by defining DBARB_ROUND_ROBIN_EN.
package dbarb_types;

    typedef enum logic [1:0] {IDLE, ARMED, DONE} dbarb_state_t;

    localparam int NREQ_MAX = 4;

    typedef logic [1:0] idx_t;

    // CPU major-state encoding of DB2, must track the CPU's parameter set
    localparam logic [4:0] ST_DB2 = 5'd12;

endpackage

// File: rtl/db_arbiter_if.sv
// Bus between the peripheral requesters / CPU and the data-break arbiter.
// slave: the arbiter's view; master: the requesters and CPU side.
interface db_arbiter_if #(parameter int NREQ = 2);

    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_to_dev;
    logic [NREQ-1:0][0:14]   req_addr;
    logic [NREQ-1:0][0:11]   req_wdata;
    logic [NREQ-1:0]         ack;
    logic [0:11]             rdata;

    logic [4:0]              state;
    logic                    break_in_prog;
    logic                    data_break;
    logic                    to_disk;
    logic [0:14]             dmaAddr;
    logic [0:11]             dmaDOUT;
    logic [0:11]             dmaDIN;

    modport slave (
        input  req, req_to_dev, req_addr, req_wdata, state, break_in_prog, dmaDIN,
        output ack, rdata, data_break, to_disk, dmaAddr, dmaDOUT
    );

    modport master (
        output req, req_to_dev, req_addr, req_wdata, state, break_in_prog, dmaDIN,
        input  ack, rdata, data_break, to_disk, dmaAddr, dmaDOUT
    );

endinterface

// File: rtl/db_arbiter_pick.sv
// Combinational winner picker. Fixed mode: lowest set index wins.
// With DBARB_ROUND_ROBIN_EN the search starts at ptr and wraps.
module dbarb_pick
    import dbarb_types::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
`ifdef DBARB_ROUND_ROBIN_EN
    input  idx_t            ptr,
`endif
    output logic            valid,
    output idx_t            idx
);

`ifdef DBARB_ROUND_ROBIN_EN
    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] rot;

    // Rotate the request vector so ptr lands at bit 0, then take the lowest set bit;
    // scanning downwards lets the nearest-to-pointer hit overwrite farther ones
    always_comb begin
        dbl   = {req, req};
        rot   = dbl >> ptr;
        valid = |req;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = (int'(ptr) + i >= NREQ) ? idx_t'(int'(ptr) + i - NREQ)
                                              : idx_t'(int'(ptr) + i);
            end
        end
    end
`else
    // Fixed priority: index 0 (disk) beats everyone
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) idx = idx_t'(i);
        end
    end
`endif

endmodule

// File: rtl/db_arbiter.sv
// Data-break arbiter: picks one requester, latches its address/direction/data,
// raises data_break until the CPU reaches DB2, then acks the winner.
// Optional rotating priority under DBARB_ROUND_ROBIN_EN.
module db_arbiter
    import dbarb_types::*;
#(
    parameter int NREQ = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    db_arbiter_if.slave  bus
);

    dbarb_state_t state_q, state_d;

    logic            pick_valid;
    idx_t            pick_idx;
    idx_t            win_q;
    logic            kill_q;
    logic            latch_en;
    logic            fin;
    logic            drop;
    logic [NREQ-1:0] ack_hot;

    logic [NREQ-1:0] ack_q;
    logic [0:11]     rdata_q;
    logic            break_q;
    logic            to_disk_q;
    logic [0:14]     addr_q;
    logic [0:11]     dout_q;

`ifdef DBARB_ROUND_ROBIN_EN
    idx_t ptr_q;

    dbarb_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Priority pointer: moves past each acked winner, homes on clear/reset
    always_ff @(posedge clk) begin
        if (reset || clear)
            ptr_q <= '0;
        else if (fin)
            ptr_q <= (win_q == idx_t'(NREQ - 1)) ? '0 : win_q + idx_t'(1);
    end
`else
    dbarb_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and datapath strobes; a break killed by clear still runs to DB2
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        fin      = 1'b0;
        drop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!clear && pick_valid) begin
                    latch_en = 1'b1;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (clear && !bus.break_in_prog) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else if (bus.state == ST_DB2) begin
                    drop = 1'b1;
                    if (kill_q || clear) begin
                        state_d = IDLE;
                    end else begin
                        fin     = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One-hot of the latched winner, used for the ack pulse
    always_comb begin
        ack_hot = '0;
        for (int i = 0; i < NREQ; i++) ack_hot[i] = (win_q == idx_t'(i));
    end

    // Latches, break request, ack pulse and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q     <= '0;
            kill_q    <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            break_q   <= 1'b0;
            to_disk_q <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
        end else begin
            ack_q <= '0;
            if (latch_en) begin
                win_q   <= pick_idx;
                kill_q  <= 1'b0;
                break_q <= 1'b1;
                for (int i = 0; i < NREQ; i++) begin
                    if (pick_idx == idx_t'(i)) begin
                        addr_q    <= bus.req_addr[i];
                        dout_q    <= bus.req_wdata[i];
                        to_disk_q <= bus.req_to_dev[i];
                    end
                end
            end
            if (state_q == ARMED && clear) kill_q <= 1'b1;
            if (drop) break_q <= 1'b0;
            if (fin) begin
                ack_q <= ack_hot;
                if (to_disk_q) rdata_q <= bus.dmaDIN;
            end
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rdata      = rdata_q;
    assign bus.data_break = break_q;
    assign bus.to_disk    = to_disk_q;
    assign bus.dmaAddr    = addr_q;
    assign bus.dmaDOUT    = dout_q;

endmodule
